// File: rtl/sys_pll_reset_seq.sv
// rtl/sys_pll_reset_seq.sv - PLL reset sequencer with lock qualification and staggered reset release
module sys_pll_reset_seq #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RELEASE_STAGGER     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       soft_reset_req,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       sdram_reset_n,
    output logic       ready,
    output logic [7:0] relock_count
);

    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_B   = (LOCK_STABLE_CYCLES > RELEASE_STAGGER) ? LOCK_STABLE_CYCLES : RELEASE_STAGGER;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(RELEASE_STAGGER - 1);

    localparam logic [2:0] S_PLL_RESET = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   lock_s;
    logic [2:0]             state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   lock_lost;

    assign lock_s = lock_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // The cycle in WAIT_LOCK that first sees lock already counts toward stability.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        lock_lost = 1'b0;
        case (state)
            S_PLL_RESET: begin
                if (cnt == RST_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (soft_reset_req) begin
                    state_nxt = S_PLL_RESET;
                    cnt_nxt   = '0;
                end else if (lock_s) begin
                    if (LOCK_STABLE_CYCLES <= 1) begin
                        state_nxt = S_RELEASE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = S_STABLE;
                        cnt_nxt   = CW'(1);
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = S_PLL_RESET;
                    cnt_nxt   = '0;
                end
            end
            S_STABLE: begin
                if (soft_reset_req) begin
                    state_nxt = S_PLL_RESET;
                    cnt_nxt   = '0;
                end else if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = S_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    lock_lost = 1'b1;
                    state_nxt = S_PLL_RESET;
                    cnt_nxt   = '0;
                end else if (soft_reset_req) begin
                    state_nxt = S_PLL_RESET;
                    cnt_nxt   = '0;
                end else if (cnt == STAGGER_LAST) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                cnt_nxt = cnt;
                if (!lock_s) begin
                    lock_lost = 1'b1;
                    state_nxt = S_PLL_RESET;
                    cnt_nxt   = '0;
                end else if (soft_reset_req) begin
                    state_nxt = S_PLL_RESET;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_PLL_RESET;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_PLL_RESET;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            sys_reset_n   <= 1'b0;
            sdram_reset_n <= 1'b0;
            ready         <= 1'b0;
            relock_count  <= 8'd0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            pll_rst       <= (state_nxt == S_PLL_RESET);
            sys_reset_n   <= (state_nxt == S_RELEASE) || (state_nxt == S_RUN);
            sdram_reset_n <= (state_nxt == S_RUN);
            ready         <= (state_nxt == S_RUN);
            if (lock_lost && (relock_count != 8'hFF)) begin
                relock_count <= relock_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sys_pll_reset_seq.sv
// tb/tb_sys_pll_reset_seq.sv - directed and randomized checks of sys_pll_reset_seq against a phase model
module tb_sys_pll_reset_seq;

    localparam int SYNC    = 2;
    localparam int RST_CYC = 4;
    localparam int TIMEOUT = 32;
    localparam int STABLE  = 8;
    localparam int STAGGER = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       soft_reset_req;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       sdram_reset_n;
    logic       ready;
    logic [7:0] relock_count;

    int tests = 0;
    int fails = 0;

    sys_pll_reset_seq #(
        .SYNC_STAGES        (SYNC),
        .PLL_RST_CYCLES     (RST_CYC),
        .LOCK_TIMEOUT_CYCLES(TIMEOUT),
        .LOCK_STABLE_CYCLES (STABLE),
        .RELEASE_STAGGER    (STAGGER)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .soft_reset_req(soft_reset_req),
        .pll_rst       (pll_rst),
        .sys_reset_n   (sys_reset_n),
        .sdram_reset_n (sdram_reset_n),
        .ready         (ready),
        .relock_count  (relock_count)
    );

    always #5 clk = ~clk;

    // Reference model: phase, time spent in phase, lock streak, and a history of sampled lock values.
    typedef enum int {M_PLLRST, M_WAIT, M_STABLE, M_REL, M_RUN} mph_t;
    mph_t m_ph;
    int   m_age;
    int   m_streak;
    int   m_relocks;
    bit   m_samp[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = M_PLLRST;
        m_age = 0;
        m_streak = 0;
        m_relocks = 0;
        m_samp.delete();
    endtask

    task automatic enter(input mph_t p);
        m_ph = p;
        m_age = 0;
    endtask

    task automatic model_step(input bit lk, input bit sr);
        bit ls;
        ls = (m_samp.size() >= SYNC) ? m_samp[m_samp.size() - SYNC] : 1'b0;
        case (m_ph)
            M_PLLRST: begin
                m_age++;
                if (m_age == RST_CYC) enter(M_WAIT);
            end
            M_WAIT: begin
                if (sr) enter(M_PLLRST);
                else if (ls) begin
                    m_streak = 1;
                    enter(m_streak >= STABLE ? M_REL : M_STABLE);
                end else begin
                    m_age++;
                    if (m_age == TIMEOUT) enter(M_PLLRST);
                end
            end
            M_STABLE: begin
                if (sr) enter(M_PLLRST);
                else if (!ls) enter(M_WAIT);
                else begin
                    m_streak++;
                    if (m_streak == STABLE) enter(M_REL);
                end
            end
            M_REL, M_RUN: begin
                if (!ls) begin
                    if (m_relocks < 255) m_relocks++;
                    enter(M_PLLRST);
                end else if (sr) enter(M_PLLRST);
                else if (m_ph == M_REL) begin
                    m_age++;
                    if (m_age == STAGGER) enter(M_RUN);
                end
            end
            default: enter(M_PLLRST);
        endcase
        m_samp.push_back(lk);
        if (m_samp.size() > 8) void'(m_samp.pop_front());
    endtask

    task automatic model_check();
        chk("model_pll_rst", {7'd0, pll_rst}, {7'd0, m_ph == M_PLLRST});
        chk("model_sys_reset_n", {7'd0, sys_reset_n}, {7'd0, (m_ph == M_REL) || (m_ph == M_RUN)});
        chk("model_sdram_reset_n", {7'd0, sdram_reset_n}, {7'd0, m_ph == M_RUN});
        chk("model_ready", {7'd0, ready}, {7'd0, m_ph == M_RUN});
        chk("model_relock_count", relock_count, 8'(m_relocks));
    endtask

    task automatic tick();
        bit lk, sr, rn;
        lk = pll_locked;
        sr = soft_reset_req;
        rn = reset_n;
        @(posedge clk);
        if (rn) model_step(lk, sr);
        #1;
        model_check();
    endtask

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget && ready !== 1'b1; i++) tick();
        chk("wait_ready", {7'd0, ready}, 8'd1);
    endtask

    task automatic wait_pll_rst_low(input int budget);
        for (int i = 0; i < budget && pll_rst !== 1'b0; i++) tick();
        chk("wait_pll_rst_low", {7'd0, pll_rst}, 8'd0);
    endtask

    initial begin
        int hold;
        reset_n = 1'b0;
        pll_locked = 1'b0;
        soft_reset_req = 1'b0;
        model_reset();
        #2;
        repeat (3) tick();
        chk("reset_pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("reset_sys", {7'd0, sys_reset_n}, 8'd0);
        chk("reset_sdram", {7'd0, sdram_reset_n}, 8'd0);
        chk("reset_ready", {7'd0, ready}, 8'd0);
        chk("reset_relock", relock_count, 8'd0);
        reset_n = 1'b1;

        // Clean bring-up, lock rising right after edge 10
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 3)  chk("bringup_pll_rst_e3", {7'd0, pll_rst}, 8'd1);
            if (e == 4)  chk("bringup_pll_rst_e4", {7'd0, pll_rst}, 8'd0);
            if (e == 19) chk("bringup_sys_e19", {7'd0, sys_reset_n}, 8'd0);
            if (e == 20) chk("bringup_sys_e20", {7'd0, sys_reset_n}, 8'd1);
            if (e == 22) chk("bringup_sdram_e22", {7'd0, sdram_reset_n}, 8'd0);
            if (e == 23) begin
                chk("bringup_sdram_e23", {7'd0, sdram_reset_n}, 8'd1);
                chk("bringup_ready_e23", {7'd0, ready}, 8'd1);
            end
            if (e == 10) pll_locked = 1'b1;
        end
        chk("bringup_relock", relock_count, 8'd0);

        // Lock loss in RUN
        pll_locked = 1'b0;
        tick();
        tick();
        chk("loss_ready_e2", {7'd0, ready}, 8'd1);
        tick();
        chk("loss_pll_rst_e3", {7'd0, pll_rst}, 8'd1);
        chk("loss_sys_e3", {7'd0, sys_reset_n}, 8'd0);
        chk("loss_sdram_e3", {7'd0, sdram_reset_n}, 8'd0);
        chk("loss_ready_e3", {7'd0, ready}, 8'd0);
        chk("loss_relock", relock_count, 8'd1);
        pll_locked = 1'b1;
        wait_ready(200);

        // Soft reset in RUN
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        chk("soft_pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("soft_sys", {7'd0, sys_reset_n}, 8'd0);
        chk("soft_ready", {7'd0, ready}, 8'd0);
        chk("soft_relock", relock_count, 8'd1);
        wait_ready(200);

        // Soft request on the same edge as a synced lock loss
        pll_locked = 1'b0;
        tick();
        tick();
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        chk("prec_pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("prec_relock", relock_count, 8'd2);

        // Glitchy lock: 5 high, 1 low, then high
        wait_pll_rst_low(20);
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 9)  chk("glitch_sys_e9", {7'd0, sys_reset_n}, 8'd0);
            if (e == 10) chk("glitch_sys_e10", {7'd0, sys_reset_n}, 8'd1);
        end

        // Timeout with lock held low
        soft_reset_req = 1'b1;
        pll_locked = 1'b0;
        tick();
        soft_reset_req = 1'b0;
        wait_pll_rst_low(20);
        for (int e = 1; e <= 68; e++) begin
            tick();
            if (e == 31) chk("timeout_pll_rst_e31", {7'd0, pll_rst}, 8'd0);
            if (e == 32) chk("timeout_pll_rst_e32", {7'd0, pll_rst}, 8'd1);
            if (e == 35) chk("timeout_pll_rst_e35", {7'd0, pll_rst}, 8'd1);
            if (e == 36) chk("timeout_pll_rst_e36", {7'd0, pll_rst}, 8'd0);
            if (e == 67) chk("timeout_pll_rst_e67", {7'd0, pll_rst}, 8'd0);
            if (e == 68) chk("timeout_pll_rst_e68", {7'd0, pll_rst}, 8'd1);
        end
        chk("timeout_relock", relock_count, 8'd2);

        // Randomized lock and soft-request activity against the model
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                pll_locked = ($urandom_range(0, 3) != 0);
                hold = $urandom_range(1, 40);
            end
            hold--;
            soft_reset_req = ($urandom_range(0, 63) == 0);
            tick();
        end
        soft_reset_req = 1'b0;

        // Repeated lock loss saturates the counter
        for (int n = 0; n < 300; n++) begin
            pll_locked = 1'b1;
            wait_ready(80);
            pll_locked = 1'b0;
            repeat (3) tick();
        end
        chk("saturate_relock", relock_count, 8'd255);

        // Asynchronous reset in the middle of RELEASE
        pll_locked = 1'b1;
        for (int i = 0; i < 100 && !(sys_reset_n === 1'b1 && sdram_reset_n === 1'b0); i++) tick();
        chk("in_release_sys", {7'd0, sys_reset_n}, 8'd1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("async_sys", {7'd0, sys_reset_n}, 8'd0);
        chk("async_sdram", {7'd0, sdram_reset_n}, 8'd0);
        chk("async_ready", {7'd0, ready}, 8'd0);
        chk("async_relock", relock_count, 8'd0);
        tick();
        reset_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 4) chk("rerelease_pll_rst_e4", {7'd0, pll_rst}, 8'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
